// File: rtl/key_bank.sv
// key_bank: per-key synchronise, debounce and auto-repeat for a bank of
// push buttons. Each channel is independent. o_level is the debounced
// state, o_press/o_release are one-cycle edge pulses coincident with the
// o_level change, and o_rep pulses on the press and on every auto-repeat.
// o_dbg_state exposes each channel's repeat FSM state (2 bits per key,
// key 0 in the low bits) so checkers can observe it directly.
module key_bank #(
   parameter int N_KEYS     = 4,
   parameter int STABLE_CYC = 16,
   parameter int REP_DELAY  = 250000,
   parameter int REP_PERIOD = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N_KEYS-1:0]     i_key,
   input  logic [N_KEYS-1:0]     i_rep_en,
   output logic [N_KEYS-1:0]     o_level,
   output logic [N_KEYS-1:0]     o_press,
   output logic [N_KEYS-1:0]     o_release,
   output logic [N_KEYS-1:0]     o_rep,
   output logic                  o_any,
   output logic [2*N_KEYS-1:0]   o_dbg_state
);

   // Pin level that means "not pressed"; also the synchroniser reset value.
   localparam logic RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   // Debounce counter only ever reaches STABLE_CYC-1 before clearing.
   localparam int DB_W = $clog2(STABLE_CYC + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYC - 1);

   // Repeat counter sized for the longer of the two intervals.
   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2,
      ST_HOLD   = 2'd3
   } rep_state_t;

   genvar g;
   generate
      for (g = 0; g < N_KEYS; g++) begin : g_key
         logic            sync1_q;
         logic            sync2_q;
         logic            key_now;
         logic [DB_W-1:0] db_cnt_q;
         logic            level_q;
         logic            press_q;
         logic            release_q;
         logic            accept;
         logic            press_evt;
         logic            release_evt;
         rep_state_t      state_q;
         rep_state_t      state_d;
         logic [REP_W-1:0] rep_cnt_q;
         logic [REP_W-1:0] rep_cnt_d;
         logic            rep_q;
         logic            rep_d;

         // Two-flop synchroniser on the raw asynchronous pin.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               sync1_q <= RELEASED_PIN;
               sync2_q <= RELEASED_PIN;
            end else begin
               sync1_q <= i_key[g];
               sync2_q <= sync1_q;
            end
         end

         // Normalised sample: 1 means pressed regardless of pin polarity.
         assign key_now     = sync2_q ^ RELEASED_PIN;
         // A change is accepted on the STABLE_CYC-th consecutive differing sample.
         assign accept      = (key_now != level_q) && (db_cnt_q == DB_LAST);
         assign press_evt   = accept & key_now;
         assign release_evt = accept & ~key_now;

         // Debounce counter, stable level and registered edge pulses.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               db_cnt_q  <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               press_q   <= press_evt;
               release_q <= release_evt;
               if (key_now == level_q) begin
                  db_cnt_q <= '0;
               end else if (accept) begin
                  db_cnt_q <= '0;
                  level_q  <= key_now;
               end else begin
                  db_cnt_q <= db_cnt_q + DB_W'(1);
               end
            end
         end

         // Repeat FSM next state; release has priority over any repeat expiry.
         always_comb begin
            state_d   = state_q;
            rep_cnt_d = rep_cnt_q;
            rep_d     = 1'b0;
            if (release_evt) begin
               state_d   = ST_IDLE;
               rep_cnt_d = '0;
            end else if (press_evt) begin
               rep_d     = 1'b1;
               rep_cnt_d = '0;
               state_d   = i_rep_en[g] ? ST_DELAY : ST_HOLD;
            end else begin
               case (state_q)
                  ST_DELAY: begin
                     if (!i_rep_en[g]) begin
                        state_d   = ST_HOLD;
                        rep_cnt_d = '0;
                     end else if (rep_cnt_q == DELAY_LAST) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = '0;
                        state_d   = ST_REPEAT;
                     end else begin
                        rep_cnt_d = rep_cnt_q + REP_ONE;
                     end
                  end
                  ST_REPEAT: begin
                     if (!i_rep_en[g]) begin
                        state_d   = ST_HOLD;
                        rep_cnt_d = '0;
                     end else if (rep_cnt_q == PERIOD_LAST) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = '0;
                     end else begin
                        rep_cnt_d = rep_cnt_q + REP_ONE;
                     end
                  end
                  default: begin
                     state_d = state_q;
                  end
               endcase
            end
         end

         // Repeat FSM state, counter and registered repeat pulse.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               state_q   <= ST_IDLE;
               rep_cnt_q <= '0;
               rep_q     <= 1'b0;
            end else begin
               state_q   <= state_d;
               rep_cnt_q <= rep_cnt_d;
               rep_q     <= rep_d;
            end
         end

         assign o_level[g]             = level_q;
         assign o_press[g]             = press_q;
         assign o_release[g]           = release_q;
         assign o_rep[g]               = rep_q;
         assign o_dbg_state[2*g +: 2]  = state_q;
      end
   endgenerate

   assign o_any = |o_press;

endmodule

// File: tb/tb_key_bank.sv
// tb_key_bank: randomised and directed stimulus for key_bank, checked
// cycle by cycle against a behavioural model built from the debounce and
// repeat timing rules (sliding sample window, press-relative repeat times).
module tb_key_bank;
   localparam int N = 4;
   localparam int S = 8;
   localparam int D = 20;
   localparam int P = 5;
   localparam int W = 4 * N + 1;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] i_key = '1;
   logic [N-1:0] i_rep_en = '0;
   logic [N-1:0] o_level, o_press, o_release, o_rep;
   logic         o_any;
   logic [2*N-1:0] o_dbg_state;

   initial forever #5 clk = ~clk;

   key_bank #(
      .N_KEYS(N), .STABLE_CYC(S), .REP_DELAY(D), .REP_PERIOD(P), .ACTIVE_LOW(1)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_key(i_key), .i_rep_en(i_rep_en),
      .o_level(o_level), .o_press(o_press), .o_release(o_release),
      .o_rep(o_rep), .o_any(o_any), .o_dbg_state(o_dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [S+1:0] hist [N];   // bit i = pressed level sampled i edges ago
   logic         stable [N];
   logic         alive [N];  // auto-repeat still permitted for this press
   int           press_t [N];
   int           cyc = 0;

   function automatic logic [W-1:0] actual();
      return {o_any, o_rep, o_release, o_press, o_level};
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h (any,rep,rel,press,level)", name, $time, got, exp);
      end
   endtask

   // Model one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [N-1:0] lv, pr, rl, rp;
      logic acc;
      int   d;
      lv = '0; pr = '0; rl = '0; rp = '0;
      if (!rst_n) begin
         cyc = 0;
         for (int j = 0; j < N; j++) begin
            hist[j] = '0; stable[j] = 1'b0; alive[j] = 1'b0; press_t[j] = 0;
         end
      end else begin
         cyc++;
         for (int j = 0; j < N; j++) begin
            hist[j] = {hist[j][S:0], ~i_key[j]};
            // The debounce logic sees samples 2..S+1 edges old; all must oppose stable.
            acc = 1'b1;
            for (int i = 2; i <= S + 1; i++)
               if (hist[j][i] == stable[j]) acc = 1'b0;
            if (acc && !stable[j]) begin
               stable[j]  = 1'b1;
               pr[j]      = 1'b1;
               rp[j]      = 1'b1;
               press_t[j] = cyc;
               alive[j]   = i_rep_en[j];
            end else if (acc && stable[j]) begin
               stable[j] = 1'b0;
               rl[j]     = 1'b1;
               alive[j]  = 1'b0;
            end else if (stable[j] && alive[j]) begin
               if (!i_rep_en[j]) begin
                  alive[j] = 1'b0;
               end else begin
                  d = cyc - press_t[j];
                  if (d == D || (d > D && ((d - D) % P) == 0)) rp[j] = 1'b1;
               end
            end
            lv[j] = stable[j];
         end
      end
      exp_q.push_back({|pr, rp, rl, pr, lv});
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic rst, input logic [N-1:0] kp, input logic [N-1:0] ren);
      @(negedge clk);
      if (!rst && rst_n) begin
         rst_n = 1'b0;
         #1;
         check("async_reset_clear", actual(), '0);
      end
      rst_n    = rst;
      i_key    = ~kp;
      i_rep_en = ren;
      model_edge();
   endtask

   task automatic hold(input logic rst, input logic [N-1:0] kp, input logic [N-1:0] ren, input int n);
      for (int i = 0; i < n; i++) step(rst, kp, ren);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", actual(), e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int run_left [N];
      logic [N-1:0] kp_r, ren_r;
      int idx;

      #1 rst_n = 1'b0;
      #1 check("reset_state", actual(), '0);

      hold(1'b0, 4'b0000, 4'b0000, 3);
      // Single press, no repeat, then release
      hold(1'b1, 4'b0001, 4'b0000, 15);
      hold(1'b1, 4'b0000, 4'b0000, 15);
      // 7-cycle glitch rejected, 8-cycle pulse accepted
      hold(1'b1, 4'b0010, 4'b0000, 7);
      hold(1'b1, 4'b0000, 4'b0000, 15);
      hold(1'b1, 4'b0010, 4'b0000, 8);
      hold(1'b1, 4'b0000, 4'b0000, 20);
      // Auto-repeat on key 2, then enable dropped
      hold(1'b1, 4'b0100, 4'b0100, 55);
      hold(1'b1, 4'b0100, 4'b0000, 20);
      hold(1'b1, 4'b0000, 4'b0000, 15);
      // Simultaneous press and release on keys 0 and 3
      hold(1'b1, 4'b1001, 4'b0000, 15);
      hold(1'b1, 4'b0000, 4'b0000, 15);
      // Release accepted on the same edge as the first repeat would fire
      hold(1'b1, 4'b0100, 4'b0100, 20);
      hold(1'b1, 4'b0000, 4'b0100, 20);
      // Reset during REPEAT with the key still held
      hold(1'b1, 4'b0100, 4'b0100, 40);
      hold(1'b0, 4'b0100, 4'b0100, 3);
      hold(1'b1, 4'b0100, 4'b0100, 15);
      hold(1'b1, 4'b0000, 4'b0100, 15);

      // Randomised runs of varying length on every key
      kp_r  = '0;
      ren_r = '1;
      for (int j = 0; j < N; j++) run_left[j] = $urandom_range(1, 45);
      for (int c = 0; c < 2000; c++) begin
         for (int j = 0; j < N; j++) begin
            if (run_left[j] == 0) begin
               kp_r[j]     = ~kp_r[j];
               run_left[j] = $urandom_range(1, 45);
            end else begin
               run_left[j]--;
            end
         end
         if ($urandom_range(0, 39) == 0) begin
            idx = $urandom_range(0, N - 1);
            ren_r[idx] = ~ren_r[idx];
         end
         if ($urandom_range(0, 599) == 0) hold(1'b0, kp_r, ren_r, 2);
         step(1'b1, kp_r, ren_r);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
